// File: rtl/midori128_stream_io.sv
// midori128_stream_io
//   Word-serial front/back end for an external combinational Midori128 core.
//   It collects a key and a text block from a 32-bit valid/ready stream into
//   holding registers, and those registers drive the core's K/P/enc inputs.
//   Once a full text block and a complete key are present, it waits a
//   programmable settle time, captures the core's C output and streams the
//   result back out as 32-bit words. It contains no cipher logic.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     input word stream, most significant word first
//   in_sel                        1 = key word, 0 = text word
//   in_enc                        direction, sampled with the first text word
//   core_enc/core_k/core_p        registered drive to the cipher core
//   core_c                        cipher core result
//   out_valid/out_ready/out_data  result word stream, most significant word first
//   out_last                      final word of a result block
//   busy                          high while waiting on the core or draining
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_LOAD  | accepting key/text words; launches once text full and key set
// ST_WAIT  | core inputs frozen, counting down the settle time
// ST_DRAIN | captured result is being streamed out word by word

module midori128_stream_io #(
  parameter int WORD_W        = 32,
  parameter int BLOCK_W       = 128,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_sel,
  input  logic               in_enc,
  output logic               core_enc,
  output logic [BLOCK_W-1:0] core_k,
  output logic [BLOCK_W-1:0] core_p,
  input  logic [BLOCK_W-1:0] core_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_last,
  output logic               busy
);

  localparam int NWORDS = BLOCK_W / WORD_W;
  localparam int IW     = $clog2(NWORDS);
  localparam int DW     = $clog2(NWORDS + 1);

  localparam logic [IW-1:0] LAST_IDX    = IW'(NWORDS - 1);
  localparam logic [DW-1:0] TEXT_FULL   = DW'(NWORDS);
  localparam logic [3:0]    SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [BLOCK_W-1:0] key_reg;
  logic [BLOCK_W-1:0] text_reg;
  logic [BLOCK_W-1:0] res_reg;
  logic [IW-1:0]      kcnt;
  logic [IW-1:0]      ocnt;
  logic [DW-1:0]      dcnt;
  logic [3:0]         settle_cnt;
  logic               enc_reg;
  logic               key_loaded;

  logic in_acc;
  logic out_acc;
  logic launch;

  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;
  assign launch  = (dcnt == TEXT_FULL) && key_loaded;

  assign core_k   = key_reg;
  assign core_p   = text_reg;
  assign core_enc = enc_reg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:  if (launch) state_nxt = ST_WAIT;
      ST_WAIT:  if (settle_cnt == 4'd0) state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_ready && (ocnt == LAST_IDX)) state_nxt = ST_LOAD;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    case (state)
      // A full text block only blocks further text; key words still flow.
      ST_LOAD: in_ready = ~rst & ((dcnt != TEXT_FULL) | in_sel);
      ST_WAIT: busy = 1'b1;
      ST_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = res_reg[BLOCK_W-1-WORD_W*int'(ocnt) -: WORD_W];
        out_last  = (ocnt == LAST_IDX);
      end
      default: ;
    endcase
  end

  // Holding registers and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_reg    <= '0;
      text_reg   <= '0;
      res_reg    <= '0;
      kcnt       <= '0;
      ocnt       <= '0;
      dcnt       <= '0;
      settle_cnt <= '0;
      enc_reg    <= 1'b0;
      key_loaded <= 1'b0;
    end else begin
      if (in_acc) begin
        if (in_sel) begin
          key_reg[BLOCK_W-1-WORD_W*int'(kcnt) -: WORD_W] <= in_data;
          kcnt <= kcnt + 1'b1;
          // Cleared by the first word of a (re)load, set by its last word;
          // words in between leave it cleared.
          key_loaded <= (kcnt == LAST_IDX);
        end else begin
          text_reg[BLOCK_W-1-WORD_W*int'(dcnt[IW-1:0]) -: WORD_W] <= in_data;
          if (dcnt == '0) enc_reg <= in_enc;
          dcnt <= dcnt + 1'b1;
        end
      end

      case (state)
        ST_LOAD: begin
          if (launch) settle_cnt <= SETTLE_INIT;
        end
        ST_WAIT: begin
          if (settle_cnt == 4'd0) begin
            res_reg <= core_c;
            ocnt    <= '0;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_DRAIN: begin
          if (out_acc) begin
            ocnt <= ocnt + 1'b1;
            if (ocnt == LAST_IDX) dcnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
